assert_event_collector: RTL

ASSERT_EVENT_COLLECTOR -- requirements
Module: assert_event_collector

---
 rtl/assert_event_collector.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/assert_event_collector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : assert_event_collector                                       |
// | Description : Gathers per-source assertion-failure pulses, queues reports  |
// |               round-robin into a FIFO and keeps saturating counters.       |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module assert_event_collector #(
    parameter int N_SRC = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_SRC-1:0]           fail_i,
    input  logic                       ctl_valid_i,
    input  logic [1:0]                 ctl_op_i,
    input  logic [N_SRC-1:0]           ctl_mask_i,
    output logic [N_SRC-1:0]           en_o,
    output logic                       rpt_valid_o,
    input  logic                       rpt_ready_i,
    output logic [$clog2(N_SRC)-1:0]   rpt_src_o,
    output logic [CNT_W-1:0]           rpt_seq_o,
    output logic [CNT_W-1:0]           fail_cnt_o,
    output logic [CNT_W-1:0]           drop_cnt_o
);

    localparam int         c_src_w   = $clog2(N_SRC);
    localparam int         c_aw      = $clog2(DEPTH);
    localparam int         c_ext_w   = CNT_W + 1;
    localparam logic [1:0] c_op_on   = 2'b01;
    localparam logic [1:0] c_op_off  = 2'b10;
    localparam logic [1:0] c_op_kill = 2'b11;

    logic [N_SRC-1:0]   r_en;
    logic [N_SRC-1:0]   r_pend;
    logic [c_src_w-1:0] r_rr;
    logic [CNT_W-1:0]   r_seq;
    logic [CNT_W-1:0]   r_fail_cnt;
    logic [CNT_W-1:0]   r_drop_cnt;
    logic [c_aw:0]      r_wptr;
    logic [c_aw:0]      r_rptr;
    logic [c_src_w-1:0] r_mem_src [DEPTH];
    logic [CNT_W-1:0]   r_mem_seq [DEPTH];

    logic [N_SRC-1:0]   w_kill;
    logic [N_SRC-1:0]   w_acc;
    logic [N_SRC-1:0]   w_cand;
    logic [N_SRC-1:0]   w_deq;
    logic [N_SRC-1:0]   w_drop;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_gnt_vld;
    logic [c_src_w-1:0] w_gnt_idx;
    logic [c_src_w-1:0] w_nrr;
    logic [c_ext_w-1:0] w_fail_sum;
    logic [c_ext_w-1:0] w_drop_sum;
    logic [CNT_W-1:0]   w_fail_nxt;
    logic [CNT_W-1:0]   w_drop_nxt;

    // Gating uses the pre-edge enables; only KILL masks acceptance in its own cycle.
    assign w_kill  = (ctl_valid_i && ctl_op_i == c_op_kill) ? ctl_mask_i : '0;
    assign w_acc   = fail_i & r_en & ~w_kill;
    assign w_cand  = r_pend & ~w_kill;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[c_aw] != r_rptr[c_aw]) &&
                     (r_wptr[c_aw-1:0] == r_rptr[c_aw-1:0]);
    assign w_pop   = !w_empty && rpt_ready_i;

    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (!w_gnt_vld && w_cand[c_src_w'((int'(r_rr) + i) % N_SRC)]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = c_src_w'((int'(r_rr) + i) % N_SRC);
            end
        end
    end

    assign w_push = w_gnt_vld && (!w_full || w_pop);
    assign w_nrr  = c_src_w'((int'(w_gnt_idx) + 1) % N_SRC);
    assign w_deq  = w_push ? (N_SRC'(1) << w_gnt_idx) : '0;
    assign w_drop = w_acc & r_pend & ~w_deq;

    always_comb begin
        w_fail_sum = {1'b0, r_fail_cnt};
        w_drop_sum = {1'b0, r_drop_cnt};
        for (int k = 0; k < N_SRC; k++) begin
            w_fail_sum = w_fail_sum + c_ext_w'(w_acc[k]);
            w_drop_sum = w_drop_sum + c_ext_w'(w_drop[k]);
        end
    end

    // A carry out of the counter width means the count saturates.
    assign w_fail_nxt = w_fail_sum[CNT_W] ? '1 : w_fail_sum[CNT_W-1:0];
    assign w_drop_nxt = w_drop_sum[CNT_W] ? '1 : w_drop_sum[CNT_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en       <= '1;
            r_pend     <= '0;
            r_rr       <= '0;
            r_seq      <= '0;
            r_fail_cnt <= '0;
            r_drop_cnt <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
        end else begin
            if (ctl_valid_i) begin
                case (ctl_op_i)
                    c_op_on:             r_en <= r_en | ctl_mask_i;
                    c_op_off, c_op_kill: r_en <= r_en & ~ctl_mask_i;
                    default:             r_en <= r_en;
                endcase
            end
            r_pend     <= (r_pend & ~w_deq & ~w_kill) | w_acc;
            r_fail_cnt <= w_fail_nxt;
            r_drop_cnt <= w_drop_nxt;
            if (w_push) begin
                r_seq  <= r_seq + CNT_W'(1);
                r_rr   <= w_nrr;
                r_wptr <= r_wptr + (c_aw + 1)'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + (c_aw + 1)'(1);
            end
        end
    end

    // Storage needs no reset: the pointers alone define which slots are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_src[r_wptr[c_aw-1:0]] <= w_gnt_idx;
            r_mem_seq[r_wptr[c_aw-1:0]] <= r_seq;
        end
    end

    assign en_o        = r_en;
    assign rpt_valid_o = !w_empty;
    assign rpt_src_o   = r_mem_src[r_rptr[c_aw-1:0]];
    assign rpt_seq_o   = r_mem_seq[r_rptr[c_aw-1:0]];
    assign fail_cnt_o  = r_fail_cnt;
    assign drop_cnt_o  = r_drop_cnt;

endmodule
`default_nettype wire
